// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (write/read) arbiter and sequencer for a single-port memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on conflicts (default: write has priority).
module mem_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          addr_err,
    output logic          mem_trigger,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t        state_q, state_d;
    logic          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, addr_err_q, addr_err_d;
    logic          mem_trigger_q, mem_trigger_d, rd_valid_q, rd_valid_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_din_q, mem_din_d, rd_data_q, rd_data_d;
    logic          s1_q, s1_d, s2_q, s2_d, e1_q, e1_d, e2_q, e2_d;
    logic          go, grant_wr, bad;
    logic [AW-1:0] win_addr;
`ifdef ARB_ROUND_ROBIN_EN
    logic          rr_q, rr_d;
    // rr_q set means the next conflict goes to the reader
    assign grant_wr = wr_req & (~rd_req | ~rr_q);
    assign rr_d     = (go & wr_req & rd_req) ? grant_wr : rr_q;
`else
    assign grant_wr = wr_req;
`endif
    assign win_addr = grant_wr ? wr_addr : rd_addr;
    assign bad      = 32'(win_addr) >= DEPTH;
    assign go       = (state_q == IDLE) & (wr_req | rd_req);
    always_comb begin
        state_d       = go ? ISSUE : IDLE;
        wr_ack_d      = go & grant_wr;
        rd_ack_d      = go & ~grant_wr;
        addr_err_d    = go & bad;
        mem_trigger_d = go & grant_wr & ~bad;
        mem_address_d = go ? win_addr : mem_address_q;
        mem_din_d     = (go & grant_wr) ? wr_data : mem_din_q;
        // read pipeline: grant -> memory access -> capture mem_dout
        s1_d          = go & ~grant_wr;
        e1_d          = go & ~grant_wr & bad;
        s2_d          = s1_q;
        e2_d          = e1_q;
        rd_valid_d    = s2_q;
        rd_data_d     = s2_q ? (e2_q ? '0 : mem_dout) : rd_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            addr_err_q    <= 1'b0;
            mem_trigger_q <= 1'b0;
            mem_address_q <= '0;
            mem_din_q     <= '0;
            s1_q          <= 1'b0;
            e1_q          <= 1'b0;
            s2_q          <= 1'b0;
            e2_q          <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            addr_err_q    <= addr_err_d;
            mem_trigger_q <= mem_trigger_d;
            mem_address_q <= mem_address_d;
            mem_din_q     <= mem_din_d;
            s1_q          <= s1_d;
            e1_q          <= e1_d;
            s2_q          <= s2_d;
            e2_q          <= e2_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q          <= rr_d;
`endif
        end
    end
    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign addr_err    = addr_err_q;
    assign mem_trigger = mem_trigger_q;
    assign mem_address = mem_address_q;
    assign mem_din     = mem_din_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
endmodule
